// File: rtl/sram_pkg.sv
// Shared state encoding and sizing helpers for the parametrised SRAM model.
package sram_pkg;

  typedef logic [2:0] state_e;

  localparam state_e ST_INIT  = 3'd0;
  localparam state_e ST_IDLE  = 3'd1;
  localparam state_e ST_WRITE = 3'd2;
  localparam state_e ST_SENSE = 3'd3;
  localparam state_e ST_RESP  = 3'd4;
  localparam state_e ST_SCRUB = 3'd5;

  // The sense counter loads SENSE_CYCLES and counts down to zero, so it must hold that value.
  function automatic int sense_cnt_w(input int sense_cycles);
    return $clog2(sense_cycles + 1);
  endfunction

endpackage

// File: rtl/sram_bitcell_array.sv
// Pure storage: synchronous write on write_en_i, combinational read gated by sense_en_i.
module sram_bitcell_array #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              write_en_i,
  input  logic              sense_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (write_en_i) mem_q[addr_i] <= din_i;
  end

  assign dout_o = sense_en_i ? mem_q[addr_i] : '0;

endmodule

// File: rtl/sram_param_array.sv
// Single-port SRAM with request/response front end; FSM sequences write_en and sense_en.
// Optional SRAM_SCRUB_ON_RESET_EN zero-fills the whole array after every reset.
module sram_param_array
  import sram_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 10,
  parameter int SENSE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o
);

  localparam int CNT_W = sense_cnt_w(SENSE_CYCLES);

  generate
    if (SENSE_CYCLES < 1 || DATA_W < 1) begin : g_bad_param
      $error("sram_param_array: SENSE_CYCLES and DATA_W must both be >= 1");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              write_en, sense_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;

`ifdef SRAM_SCRUB_ON_RESET_EN
  logic [ADDR_W-1:0] scrub_q, scrub_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef SRAM_SCRUB_ON_RESET_EN
    scrub_d = scrub_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef SRAM_SCRUB_ON_RESET_EN
        state_d = ST_SCRUB;
        scrub_d = '0;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = CNT_W'(SENSE_CYCLES);
          state_d = req_we_i ? ST_WRITE : ST_SENSE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_SENSE: begin
        if (cnt_q == '0) begin
          rdata_d = mem_dout;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
`ifdef SRAM_SCRUB_ON_RESET_EN
      ST_SCRUB: begin
        scrub_d = scrub_q + ADDR_W'(1);
        if (scrub_q == '1) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
`ifdef SRAM_SCRUB_ON_RESET_EN
      scrub_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef SRAM_SCRUB_ON_RESET_EN
      scrub_q <= scrub_d;
`endif
    end
  end

  // Array strobes decode straight from state, so an async reset kills a pending write.
`ifdef SRAM_SCRUB_ON_RESET_EN
  assign write_en = (state_q == ST_WRITE) || (state_q == ST_SCRUB);
  assign mem_addr = (state_q == ST_SCRUB) ? scrub_q : addr_q;
  assign mem_din  = (state_q == ST_SCRUB) ? '0 : wdata_q;
`else
  assign write_en = (state_q == ST_WRITE);
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
`endif
  assign sense_en = (state_q == ST_SENSE);

  sram_bitcell_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i     (clk_i),
    .write_en_i(write_en),
    .sense_en_i(sense_en),
    .addr_i    (mem_addr),
    .din_i     (mem_din),
    .dout_o    (mem_dout)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_sram_param_array.sv
// Scoreboarded bench for sram_param_array: directed corner cases plus random traffic vs. an array model.
module tb_sram_param_array;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit hold    = 1'b0;

  logic [63:0] model [int];
  logic [9:0]  written_q [$];
  logic [63:0] exp_q [$];

  sram_param_array dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [63:0] ref_read(input logic [9:0] a);
    if (model.exists(int'(a))) return model[int'(a)];
    return 64'h0;
  endfunction

  // Consumer side: random backpressure unless a test holds it low.
  always @(posedge clk) begin
    #1;
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rsp_valid && prev_stall) chk("rsp_hold_stable", rsp_rdata, prev_data);
      if (rsp_valid) chk("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) timeout("unexpected_rsp");
        else chk("rsp_data", rsp_rdata, exp_q.pop_front());
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_rdata;
    end
  end

  task automatic issue(input logic we, input logic [9:0] a, input logic [63:0] d, input bit track);
    int budget = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      timeout("req_accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (track) begin
      if (we) begin
        model[int'(a)] = d;
        written_q.push_back(a);
      end else begin
        exp_q.push_back(ref_read(a));
      end
    end
    #1;
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      timeout("drain");
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    int cnt;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef SRAM_SCRUB_ON_RESET_EN
    model.delete();
    written_q.delete();
`endif
    #1;
    chk("init_busy", {63'd0, busy}, 64'd1);
    cnt = 1;
`ifdef SRAM_SCRUB_ON_RESET_EN
    while (cnt < 3 * DEPTH) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk("scrub_busy_cycles", 64'(cnt), 64'(DEPTH + 1));
`else
    @(negedge clk);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
`endif
  endtask

  initial begin
    logic [9:0]  a;
    logic [63:0] d;

    do_reset();

    // Write then read the top address.
    issue(1'b1, 10'h3FF, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    issue(1'b0, 10'h3FF, 64'h0, 1'b1);
    drain();

    // Read latency: accept at edge 0, response visible after edge 3.
    issue(1'b0, 10'h3FF, 64'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat_rsp_valid_low", {63'd0, rsp_valid}, 64'd0);
      chk("lat_req_ready_low", {63'd0, req_ready}, 64'd0);
    end
    @(negedge clk);
    chk("lat_rsp_valid_high", {63'd0, rsp_valid}, 64'd1);
    drain();

    // Consumer stall for 5 cycles.
    hold = 1'b1;
    @(posedge clk);
    issue(1'b0, 10'h3FF, 64'h0, 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("stall_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    hold = 1'b0;
    drain();

    // Back-to-back writes to one address.
    issue(1'b1, 10'd7, 64'hA, 1'b1);
    issue(1'b1, 10'd7, 64'hB, 1'b1);
    issue(1'b0, 10'd7, 64'h0, 1'b1);
    drain();

    // Reset during SENSE drops the response; stored data survives.
    issue(1'b1, 10'd5, 64'h1, 1'b1);
    issue(1'b0, 10'd5, 64'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("sense_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    do_reset();
    issue(1'b0, 10'd5, 64'h0, 1'b1);
    drain();

    // Reset during WRITE must not update the array.
    issue(1'b1, 10'd9, 64'h1111_2222_3333_4444, 1'b1);
    issue(1'b1, 10'd9, 64'h5555_6666_7777_8888, 1'b0);
    rst = 1'b1;
    do_reset();
    issue(1'b0, 10'd9, 64'h0, 1'b1);
    drain();

    // Reset while a response is stalled in RESP.
    hold = 1'b1;
    @(posedge clk);
    issue(1'b1, 10'd20, 64'h0123_4567_89AB_CDEF, 1'b1);
    issue(1'b0, 10'd20, 64'h0, 1'b0);
    repeat (4) @(negedge clk);
    chk("resp_before_rst", {63'd0, rsp_valid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("resp_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    hold = 1'b0;
    do_reset();

`ifdef SRAM_SCRUB_ON_RESET_EN
    issue(1'b0, 10'd0, 64'h0, 1'b1);
    issue(1'b0, 10'd512, 64'h0, 1'b1);
    issue(1'b0, 10'd1023, 64'h0, 1'b1);
    drain();
`endif

    // Random traffic; reads only target addresses with defined contents.
    for (int i = 0; i < 200; i++) begin
      if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 9))
          0:       a = 10'd0;
          1:       a = 10'h3FF;
          default: a = 10'($urandom_range(0, DEPTH - 1));
        endcase
        d = {$urandom, $urandom};
        issue(1'b1, a, d, 1'b1);
      end else begin
`ifdef SRAM_SCRUB_ON_RESET_EN
        a = 10'($urandom_range(0, DEPTH - 1));
`else
        a = written_q[$urandom_range(0, written_q.size() - 1)];
`endif
        issue(1'b0, a, 64'h0, 1'b1);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
